seq_rx_image_pack: RTL and testbench

SEQ_RX_IMAGE_PACK -- requirements
Module: seq_rx_image_pack

---
 rtl/seq_rx_image_pack_pkg.sv | 17 +
 rtl/seq_rx_image_pack_if.sv | 34 +++
 rtl/seq_rx_image_pack_lane.sv | 40 ++++
 rtl/seq_rx_image_pack.sv | 138 +++++++++++++
 tb/tb_seq_rx_image_pack.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_rx_image_pack_pkg.sv
// rtl/seq_rx_image_pack_pkg.sv - shared states and default parameters for the image packer
package parser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_NUM_CH       = 3;
    localparam int DEF_PIX_W        = 8;
    localparam int DEF_PIX_PER_WORD = 4;
    localparam int DEF_ADDR_W       = 14;
    localparam int DEF_DIM_W        = 8;

endpackage

// File: rtl/seq_rx_image_pack_if.sv
// rtl/seq_rx_image_pack_if.sv - pixel stream in and SRAM write bus out of the image packer
interface seq_rx_image_pack_if #(
    parameter int NUM_CH       = parser_pkg::DEF_NUM_CH,
    parameter int PIX_W        = parser_pkg::DEF_PIX_W,
    parameter int PIX_PER_WORD = parser_pkg::DEF_PIX_PER_WORD,
    parameter int ADDR_W       = parser_pkg::DEF_ADDR_W
) ();

    logic                                   pix_valid;
    logic                                   pix_ready;
    logic [NUM_CH*PIX_W-1:0]                pix_data;
    logic                                   wr_en;
    logic [ADDR_W-1:0]                      wr_addr;
    logic [NUM_CH*PIX_W*PIX_PER_WORD-1:0]   wr_data;

    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/seq_rx_image_pack_lane.sv
// rtl/seq_rx_image_pack_lane.sv - one colour plane's slot buffer; slot order set by SEQ_RX_PACK_LSB_FIRST_EN
module seq_pack_lane
    import parser_pkg::*;
#(
    parameter int PIX_W        = DEF_PIX_W,
    parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
    parameter int SLOT_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          load,
    input  logic [SLOT_W-1:0]             slot,
    input  logic [PIX_W-1:0]              din,
    output logic [PIX_W*PIX_PER_WORD-1:0] word
);

    logic [PIX_PER_WORD-1:0][PIX_W-1:0] buf_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            buf_q <= '0;
        end else if (load) begin
            buf_q[slot] <= din;
        end
    end

    // Unfilled slots stay zero because the buffer is cleared after every write.
    always_comb begin
        word = '0;
        for (int k = 0; k < PIX_PER_WORD; k++) begin
`ifdef SEQ_RX_PACK_LSB_FIRST_EN
            word[k*PIX_W +: PIX_W] = buf_q[k];
`else
            word[(PIX_PER_WORD-1-k)*PIX_W +: PIX_W] = buf_q[k];
`endif
        end
    end

endmodule

// File: rtl/seq_rx_image_pack.sv
// rtl/seq_rx_image_pack.sv - packs a pixel stream into per-plane SRAM words; slot order via SEQ_RX_PACK_LSB_FIRST_EN
module seq_rx_image_pack
    import parser_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int PIX_W        = DEF_PIX_W,
    parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DIM_W        = DEF_DIM_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIM_W-1:0]     cfg_width,
    input  logic [DIM_W-1:0]     cfg_height,
    input  logic [ADDR_W-1:0]    cfg_base_addr,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [2*DIM_W-1:0]   pix_cnt,
    seq_rx_image_pack_if.slave   bus
);

    localparam int SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int CNT_W  = 2 * DIM_W;

    state_t                         state_q, state_d;
    logic [SLOT_W-1:0]              slot_q;
    logic [ADDR_W-1:0]              word_idx_q;
    logic [ADDR_W-1:0]              base_q;
    logic [CNT_W-1:0]               total_q;
    logic [CNT_W-1:0]               pix_cnt_q;
    logic [CNT_W-1:0]               total_in;
    logic                           start_ok;
    logic                           accept;
    logic                           last_pix;
    logic                           in_write;
    logic                           buf_clr;
    logic [NUM_CH-1:0][WORD_W-1:0]  lane_word;

    assign total_in  = CNT_W'(cfg_width) * CNT_W'(cfg_height);
    assign start_ok  = (state_q == ST_IDLE) && start;
    // Abort wins over acceptance, so ready is withdrawn in the abort cycle.
    assign bus.pix_ready = (state_q == ST_ACCEPT) && !abort;
    assign accept    = bus.pix_ready && bus.pix_valid;
    assign last_pix  = (slot_q == SLOT_W'(PIX_PER_WORD - 1)) ||
                       ((pix_cnt_q + CNT_W'(1)) == total_q);
    assign in_write  = (state_q == ST_WRITE) && !abort;
    assign buf_clr   = start_ok || (state_q == ST_WRITE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (total_in != '0) ? ST_ACCEPT : ST_DONE;
                end
            end
            ST_ACCEPT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept && last_pix) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pix_cnt_q == total_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            word_idx_q <= '0;
            pix_cnt_q  <= '0;
            total_q    <= '0;
            base_q     <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                total_q    <= total_in;
                base_q     <= cfg_base_addr;
                slot_q     <= '0;
                word_idx_q <= '0;
                pix_cnt_q  <= '0;
            end else if (accept) begin
                slot_q    <= slot_q + SLOT_W'(1);
                pix_cnt_q <= pix_cnt_q + CNT_W'(1);
            end else if (in_write) begin
                slot_q     <= '0;
                word_idx_q <= word_idx_q + ADDR_W'(1);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        seq_pack_lane #(
            .PIX_W        (PIX_W),
            .PIX_PER_WORD (PIX_PER_WORD),
            .SLOT_W       (SLOT_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr  (buf_clr),
            .load (accept),
            .slot (slot_q),
            .din  (bus.pix_data[c*PIX_W +: PIX_W]),
            .word (lane_word[c])
        );
    end

    // Address arithmetic wraps naturally at ADDR_W bits.
    always_comb begin
        bus.wr_en   = in_write;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        if (in_write) begin
            bus.wr_addr = base_q + word_idx_q;
            bus.wr_data = lane_word;
        end
    end

    assign busy    = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign done    = (state_q == ST_DONE);
    assign pix_cnt = pix_cnt_q;

endmodule

// File: tb/tb_seq_rx_image_pack.sv
// tb/tb_seq_rx_image_pack.sv - randomized scoreboard bench for seq_rx_image_pack
module tb_seq_rx_image_pack;

    localparam int NUM_CH = 3;
    localparam int PIX_W  = 8;
    localparam int PPW    = 4;
    localparam int ADDR_W = 14;
    localparam int DIM_W  = 8;
    localparam int PW     = NUM_CH * PIX_W;
    localparam int WW     = PIX_W * PPW;
    localparam int DW     = NUM_CH * WW;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DIM_W-1:0]   cfg_width = '0;
    logic [DIM_W-1:0]   cfg_height = '0;
    logic [ADDR_W-1:0]  cfg_base_addr = '0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               busy;
    logic               done;
    logic [2*DIM_W-1:0] pix_cnt;

    seq_rx_image_pack_if #(.NUM_CH(NUM_CH), .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .ADDR_W(ADDR_W)) bus ();

    seq_rx_image_pack #(
        .NUM_CH(NUM_CH), .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .ADDR_W(ADDR_W), .DIM_W(DIM_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
        .cfg_base_addr (cfg_base_addr),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .pix_cnt       (pix_cnt),
        .bus           (bus)
    );

    wr_t          exp_q[$];
    logic [PW-1:0] frame_pix[$];
    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done_exp = 0;
    int cyc = 0;
    int last_wr_cyc = -10;
    bit ready_seen = 0;
    bit expect_adjacent = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each plane word is built slot by slot from the pixel list.
    task automatic push_model(input logic [ADDR_W-1:0] base, input int total, input int nwords);
        wr_t            e;
        logic [WW-1:0]  pw;
        logic [PIX_W-1:0] v;
        int             p;
        for (int w = 0; w < nwords; w++) begin
            e.addr = base + ADDR_W'(w);
            e.data = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pw = '0;
                for (int k = 0; k < PPW; k++) begin
                    p = w * PPW + k;
                    v = (p < total) ? frame_pix[p][c*PIX_W +: PIX_W] : '0;
`ifdef SEQ_RX_PACK_LSB_FIRST_EN
                    pw = pw | (WW'(v) << (k * PIX_W));
`else
                    pw = (pw << PIX_W) | WW'(v);
`endif
                end
                e.data[c*WW +: WW] = pw;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_random(input int n);
        frame_pix.delete();
        for (int i = 0; i < n; i++) frame_pix.push_back(PW'($urandom));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_wr_addr"}, bus.wr_addr, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pix_ready"}, bus.pix_ready, 0);
        check({tag, "_pix_cnt"}, pix_cnt, 0);
    endtask

    // Monitor: pops the scoreboard on every write, counts done pulses.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (bus.pix_ready) ready_seen = 1;
        if (!rst && bus.wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required none", bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr, e.addr);
                check("wr_data", bus.wr_data, e.data);
            end
            last_wr_cyc = cyc;
        end
        if (!rst && done) begin
            done_seen++;
            check("done_queue_empty", exp_q.size(), 0);
            if (expect_adjacent) check("done_after_write", cyc, last_wr_cyc + 1);
        end
    end

    task automatic run_frame(input int w, input int h, input logic [ADDR_W-1:0] base,
                             input int vprob, input int stop_after, input bit use_rst, input bit pushed);
        int total, lim, idx, n;
        total = w * h;
        lim = (stop_after < 0) ? total : stop_after;
        if (!pushed) push_model(base, total, (stop_after < 0) ? (total + PPW - 1) / PPW : stop_after / PPW);
        expect_adjacent = (stop_after < 0) && (total != 0);
        if (stop_after < 0) done_exp++;
        ready_seen = 0;
        cfg_width = DIM_W'(w);
        cfg_height = DIM_W'(h);
        cfg_base_addr = base;
        start = 1;
        tick();
        start = 0;
        cfg_width = DIM_W'($urandom);
        cfg_height = DIM_W'($urandom);
        cfg_base_addr = ADDR_W'($urandom);
        idx = 0;
        n = 0;
        while (idx < lim && n < 3000) begin
            bus.pix_valid = ($urandom_range(99) < vprob);
            bus.pix_data = frame_pix[idx];
            start = ($urandom_range(7) == 0);
            @(negedge clk);
            if (bus.pix_valid && bus.pix_ready) idx++;
            tick();
            n++;
        end
        bus.pix_valid = 0;
        start = 0;
        check("pixels_accepted", idx, lim);
        if (stop_after >= 0) begin
            if (use_rst) begin
                rst = 1;
                tick();
                rst = 0;
                @(negedge clk);
                check_zero("after_rst");
            end else begin
                abort = 1;
                tick();
                abort = 0;
                @(negedge clk);
                check("busy_after_abort", busy, 0);
                check("done_after_abort", done, 0);
            end
            check("leftover_writes", exp_q.size(), 0);
        end else begin
            n = 0;
            @(negedge clk);
            while (!done && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("done_pulse", done, 1);
            check("pix_cnt_final", pix_cnt, total);
            tick();
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("busy_idle", busy, 0);
        end
    endtask

    initial begin
        wr_t e;
        int k;
        bus.pix_valid = 0;
        bus.pix_data = '0;

        rst = 1;
        tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 0;

        // 4x2 ramp, two full words
        frame_pix.delete();
        for (int i = 0; i < 8; i++) frame_pix.push_back({3{8'(8'h10 + i)}});
`ifdef SEQ_RX_PACK_LSB_FIRST_EN
        e.addr = 14'h0; e.data = {3{32'h13121110}}; exp_q.push_back(e);
        e.addr = 14'h1; e.data = {3{32'h17161514}}; exp_q.push_back(e);
`else
        e.addr = 14'h0; e.data = {3{32'h10111213}}; exp_q.push_back(e);
        e.addr = 14'h1; e.data = {3{32'h14151617}}; exp_q.push_back(e);
`endif
        run_frame(4, 2, 14'h0, 100, -1, 0, 1);

        // 3x1 partial word
        frame_pix.delete();
        frame_pix.push_back({3{8'hA1}});
        frame_pix.push_back({3{8'hA2}});
        frame_pix.push_back({3{8'hA3}});
        e.addr = 14'h0123;
`ifdef SEQ_RX_PACK_LSB_FIRST_EN
        e.data = {3{32'h00A3A2A1}};
`else
        e.data = {3{32'hA1A2A300}};
`endif
        exp_q.push_back(e);
        run_frame(3, 1, 14'h0123, 70, -1, 0, 1);

        // zero-size frame
        frame_pix.delete();
        run_frame(0, 5, 14'h0042, 100, -1, 0, 0);
        check("zero_frame_ready_never", ready_seen, 0);

        // address wrap
        fill_random(8);
        run_frame(2, 4, 14'h3FFF, 60, -1, 0, 0);

        // abort after 5 of 8, then a clean frame
        fill_random(8);
        run_frame(4, 2, 14'h0100, 100, 5, 0, 0);
        fill_random(8);
        run_frame(4, 2, 14'h0200, 80, -1, 0, 0);

        // random frames
        for (int f = 0; f < 6; f++) begin
            int w, h;
            w = $urandom_range(1, 9);
            h = $urandom_range(1, 5);
            fill_random(w * h);
            run_frame(w, h, ADDR_W'($urandom), $urandom_range(30, 100), -1, 0, 0);
        end

        // reset mid-frame with random valid, then a clean frame
        k = $urandom_range(1, 15);
        if (k % PPW == 0) k--;
        fill_random(16);
        run_frame(4, 4, ADDR_W'($urandom), 50, k, 1, 0);
        fill_random(6);
        run_frame(3, 2, ADDR_W'($urandom), 90, -1, 0, 0);

        repeat (5) tick();
        check("done_count", done_seen, done_exp);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
